// File: rtl/e10_ex_pkg.sv
// rtl/e10_ex_pkg.sv - shared types and constants for the execute-stage sequencer
// Optional divider is enabled with E10_EX_DIV_EN.
package e10_ex_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_RUN = 2'd1,
    ST_DIV_FIX = 2'd2
  } ex_state_t;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [XLEN-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

  // Low bit of the div opcode selects unsigned; high bit selects remainder.
  function automatic logic div_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_seq_ctrl_div_step.sv
// rtl/ex_seq_ctrl_div_step.sv - one combinational radix-2 restoring divide iteration
// Used by ex_seq_ctrl when E10_EX_DIV_EN is defined.
module div_step
  import e10_ex_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quot,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quot
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_fits;

  assign w_shift = {i_rem, i_quot[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign w_fits  = (w_shift >= {1'b0, i_divisor});

  // The partial remainder is always below the divisor, so the difference fits XLEN bits.
  assign o_rem  = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign o_quot = {i_quot[XLEN-2:0], w_fits};

endmodule

// File: rtl/ex_seq_ctrl.sv
// rtl/ex_seq_ctrl.sv - execute-stage sequencer: single-cycle ALU ops plus optional iterative divider
// Divider, DIV_RUN/DIV_FIX and sign handling exist only when E10_EX_DIV_EN is defined.
module ex_seq_ctrl
  import e10_ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid_in,
  output logic        issue_ready_out,
  input  logic        is_div_in,
  input  logic [1:0]  div_op_in,
  input  logic [4:0]  alu_op_in,
  input  logic [1:0]  alu_mode_select_in,
  input  logic [31:0] pc_ex,
  input  logic [31:0] reg_1_in,
  input  logic [31:0] reg_2_in,
  input  logic [31:0] imm_data_in,
  input  logic        flush_in,
  output logic [4:0]  alu_op_out,
  output logic [1:0]  alu_mode_select_out,
  input  logic [31:0] alu_result_in,
  input  logic        alu_zero_in,
  output logic        result_valid_out,
  output logic [31:0] result_out,
  output logic        zero_out
);

  logic [31:0] r_result;
  logic        r_zero;
  logic        r_valid;

  assign result_out       = r_result;
  assign zero_out         = r_zero;
  assign result_valid_out = r_valid;

`ifdef E10_EX_DIV_EN

  ex_state_t   r_state;
  ex_state_t   w_state_nxt;
  logic [4:0]  r_alu_op;
  logic [1:0]  r_alu_mode;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_divisor;
  logic [4:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_sel_rem;

  logic        w_signed;
  logic        w_div_zero;
  logic        w_overflow;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quot_nxt;
  logic [31:0] w_fix_q;
  logic [31:0] w_fix_r;
  logic [31:0] w_fix;
  logic        w_unused;

  assign w_unused = &{1'b0, pc_ex, imm_data_in};

  assign w_signed   = div_is_signed(div_op_in);
  assign w_div_zero = (reg_2_in == 32'd0);
  assign w_overflow = w_signed && (reg_1_in == INT_MIN) && (reg_2_in == 32'hFFFF_FFFF);
  assign w_abs_a    = (w_signed && reg_1_in[31]) ? (32'd0 - reg_1_in) : reg_1_in;
  assign w_abs_b    = (w_signed && reg_2_in[31]) ? (32'd0 - reg_2_in) : reg_2_in;

  div_step u_div_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_nxt),
    .o_quot    (w_quot_nxt)
  );

  assign w_fix_q = r_neg_q ? (32'd0 - r_quot) : r_quot;
  assign w_fix_r = r_neg_r ? (32'd0 - r_rem) : r_rem;
  assign w_fix   = r_sel_rem ? w_fix_r : w_fix_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    issue_ready_out     = 1'b0;
    alu_op_out          = r_alu_op;
    alu_mode_select_out = r_alu_mode;
    case (r_state)
      ST_IDLE: begin
        issue_ready_out     = 1'b1;
        alu_op_out          = alu_op_in;
        alu_mode_select_out = alu_mode_select_in;
        if (issue_valid_in && is_div_in) begin
          w_state_nxt = (w_div_zero || w_overflow) ? ST_DIV_FIX : ST_DIV_RUN;
        end
      end
      ST_DIV_RUN: begin
        if (r_cnt == 5'(DIV_ITERS - 1)) begin
          w_state_nxt = ST_DIV_FIX;
        end
      end
      ST_DIV_FIX: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (flush_in) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= 32'd0;
      r_zero     <= 1'b0;
      r_valid    <= 1'b0;
      r_alu_op   <= 5'd0;
      r_alu_mode <= 2'd0;
      r_rem      <= 32'd0;
      r_quot     <= 32'd0;
      r_divisor  <= 32'd0;
      r_cnt      <= 5'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_sel_rem  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!flush_in) begin
        case (r_state)
          ST_IDLE: begin
            if (issue_valid_in) begin
              r_alu_op   <= alu_op_in;
              r_alu_mode <= alu_mode_select_in;
              if (is_div_in) begin
                r_cnt     <= 5'd0;
                r_sel_rem <= div_op_in[1];
                r_divisor <= w_abs_b;
                // Special cases load final values with sign flags cleared so DIV_FIX passes them through.
                if (w_div_zero) begin
                  r_quot  <= DIV_ZERO_QUOT;
                  r_rem   <= reg_1_in;
                  r_neg_q <= 1'b0;
                  r_neg_r <= 1'b0;
                end else if (w_overflow) begin
                  r_quot  <= INT_MIN;
                  r_rem   <= 32'd0;
                  r_neg_q <= 1'b0;
                  r_neg_r <= 1'b0;
                end else begin
                  r_quot  <= w_abs_a;
                  r_rem   <= 32'd0;
                  r_neg_q <= w_signed && (reg_1_in[31] ^ reg_2_in[31]);
                  r_neg_r <= w_signed && reg_1_in[31];
                end
              end else begin
                r_result <= alu_result_in;
                r_zero   <= alu_zero_in;
                r_valid  <= 1'b1;
              end
            end
          end
          ST_DIV_RUN: begin
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
            r_cnt  <= r_cnt + 5'd1;
          end
          ST_DIV_FIX: begin
            r_result <= w_fix;
            r_zero   <= (w_fix == 32'd0);
            r_valid  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`else

  logic w_unused;

  assign w_unused = &{1'b0, is_div_in, div_op_in, pc_ex, reg_1_in, reg_2_in, imm_data_in};

  assign issue_ready_out     = 1'b1;
  assign alu_op_out          = alu_op_in;
  assign alu_mode_select_out = alu_mode_select_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= 32'd0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (issue_valid_in && !flush_in) begin
        r_result <= alu_result_in;
        r_zero   <= alu_zero_in;
        r_valid  <= 1'b1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_ex_seq_ctrl.sv
// tb/tb_ex_seq_ctrl.sv - scoreboard bench for ex_seq_ctrl with an external ALU model
module tb_ex_seq_ctrl;

`ifdef E10_EX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid_in = 1'b0;
  logic        issue_ready_out;
  logic        is_div_in = 1'b0;
  logic [1:0]  div_op_in = 2'd0;
  logic [4:0]  alu_op_in = 5'd0;
  logic [1:0]  alu_mode_select_in = 2'd0;
  logic [31:0] pc_ex = 32'd0;
  logic [31:0] reg_1_in = 32'd0;
  logic [31:0] reg_2_in = 32'd0;
  logic [31:0] imm_data_in = 32'd0;
  logic        flush_in = 1'b0;
  logic [4:0]  alu_op_out;
  logic [1:0]  alu_mode_select_out;
  logic [31:0] alu_result_in;
  logic        alu_zero_in;
  logic        result_valid_out;
  logic [31:0] result_out;
  logic        zero_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;
  exp_t sb[$];

  ex_seq_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .issue_valid_in      (issue_valid_in),
    .issue_ready_out     (issue_ready_out),
    .is_div_in           (is_div_in),
    .div_op_in           (div_op_in),
    .alu_op_in           (alu_op_in),
    .alu_mode_select_in  (alu_mode_select_in),
    .pc_ex               (pc_ex),
    .reg_1_in            (reg_1_in),
    .reg_2_in            (reg_2_in),
    .imm_data_in         (imm_data_in),
    .flush_in            (flush_in),
    .alu_op_out          (alu_op_out),
    .alu_mode_select_out (alu_mode_select_out),
    .alu_result_in       (alu_result_in),
    .alu_zero_in         (alu_zero_in),
    .result_valid_out    (result_valid_out),
    .result_out          (result_out),
    .zero_out            (zero_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU: 0 ADD, 1 SUB, 2 XOR, 3 OR, else AND; mode picks operand pair.
  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [1:0] mode,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] imm, input logic [31:0] pc);
    logic [31:0] x, y;
    case (mode)
      2'd0: begin x = a;  y = b;   end
      2'd1: begin x = a;  y = imm; end
      2'd2: begin x = pc; y = imm; end
      default: begin x = pc; y = b; end
    endcase
    case (op)
      5'd0: return x + y;
      5'd1: return x - y;
      5'd2: return x ^ y;
      5'd3: return x | y;
      default: return x & y;
    endcase
  endfunction

  always_comb begin
    alu_result_in = alu_fn(alu_op_out, alu_mode_select_out, reg_1_in, reg_2_in, imm_data_in, pc_ex);
    alu_zero_in   = (alu_result_in == 32'd0);
  end

  function automatic bit div_special(input logic [1:0] dop, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!dop[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] div_ref(input logic [1:0] dop, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!dop[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (!dop[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return dop[1] ? r : q;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && result_valid_out) begin
      if (sb.size() == 0) begin
        chk("spurious_strobe", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result_out, e.res);
        chk("zero", {31'd0, zero_out}, {31'd0, e.res == 32'd0});
        chk("latency", cyc, e.due);
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic d, input logic [1:0] dop, input logic [4:0] op,
                       input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc, input bit track);
    int n;
    exp_t e;
    n = 0;
    while (!issue_ready_out && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_issue", {31'd0, issue_ready_out}, 32'd1);
    is_div_in = d; div_op_in = dop; alu_op_in = op; alu_mode_select_in = mode;
    reg_1_in = a; reg_2_in = b; imm_data_in = imm; pc_ex = pc;
    issue_valid_in = 1'b1;
    if (DIV_EN && d) begin
      e.res = div_ref(dop, a, b);
      e.due = cyc + (div_special(dop, a, b) ? 2 : 34);
    end else begin
      e.res = alu_fn(op, mode, a, b, imm, pc);
      e.due = cyc + 1;
    end
    if (track || !(DIV_EN && d)) sb.push_back(e);
    @(posedge clk); #1;
    issue_valid_in = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] a, b;
    logic [1:0]  dop;
    logic        d;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, result_valid_out}, 32'd0);
    chk("rst_result", result_out, 32'd0);
    chk("rst_zero", {31'd0, zero_out}, 32'd0);
    chk("rst_ready", {31'd0, issue_ready_out}, 32'd1);
    chk("rst_alu_op", {27'd0, alu_op_out}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(1'b0, 2'd0, 5'd0, 2'd0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b1);
    issue(1'b0, 2'd0, 5'd1, 2'd0, 32'd7, 32'd7, 32'd0, 32'd0, 1'b1);

    issue(1'b1, 2'b00, 5'd0, 2'd0, 32'hFFFF_FFEC, 32'd3, 32'd0, 32'd0, 1'b1);
    n = 0;
    repeat (33) begin
      if (issue_ready_out !== !DIV_EN) n++;
      @(posedge clk); #1;
    end
    chk("ready_during_div", n, 32'd0);
    issue(1'b1, 2'b10, 5'd0, 2'd0, 32'hFFFF_FFEC, 32'd3, 32'd0, 32'd0, 1'b1);
    issue(1'b1, 2'b01, 5'd0, 2'd0, 32'd7, 32'd0, 32'd0, 32'd0, 1'b1);
    issue(1'b1, 2'b11, 5'd0, 2'd0, 32'd7, 32'd0, 32'd0, 32'd0, 1'b1);
    issue(1'b1, 2'b00, 5'd0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
    issue(1'b1, 2'b10, 5'd0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);

    issue(1'b1, 2'b01, 5'd0, 2'd0, 32'd1000, 32'd9, 32'd0, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    chk("flush_ready", {31'd0, issue_ready_out}, 32'd1);
    issue(1'b0, 2'd0, 5'd0, 2'd1, 32'd40, 32'd0, 32'd2, 32'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    issue(1'b1, 2'b00, 5'd3, 2'd2, 32'd123456, 32'd77, 32'd5, 32'd8, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    alu_op_in = 5'd0;
    alu_mode_select_in = 2'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", {31'd0, result_valid_out}, 32'd0);
    chk("midrst_result", result_out, 32'd0);
    chk("midrst_zero", {31'd0, zero_out}, 32'd0);
    chk("midrst_ready", {31'd0, issue_ready_out}, 32'd1);
    chk("midrst_alu_mode", {30'd0, alu_mode_select_out}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      d   = ($urandom_range(0, 2) == 0);
      dop = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = 32'd0 - 32'($urandom_range(1, 15));
        default: ;
      endcase
      issue(d, dop, 5'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), a, b,
            $urandom, $urandom, 1'b1);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
